// File: rtl/game_round_ctrl_if.sv
// Sprite/controller bundle for game_round_ctrl.
// master: position-update side (drives tick, start, positions, pellet pulses).
// slave:  round controller (drives state, lives, score and sprite strobes).
interface game_round_ctrl_if #(
  parameter int NUM_GHOSTS = 4,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int SCORE_W    = 12
);
  logic                        tick;
  logic                        start;
  logic [X_W-1:0]              pacman_x;
  logic [Y_W-1:0]              pacman_y;
  logic [NUM_GHOSTS*X_W-1:0]   ghost_x;
  logic [NUM_GHOSTS*Y_W-1:0]   ghost_y;
  logic                        food_eaten;
  logic                        power_eaten;
  logic [2:0]                  state;
  logic [2:0]                  lives;
  logic [SCORE_W-1:0]          score;
  logic                        freeze;
  logic                        respawn;
  logic                        pacman_dead;
  logic                        game_over;
  logic                        frightened;
  logic [NUM_GHOSTS-1:0]       ghost_eaten;

  modport master (
    output tick, start, pacman_x, pacman_y, ghost_x, ghost_y, food_eaten, power_eaten,
    input  state, lives, score, freeze, respawn, pacman_dead, game_over, frightened, ghost_eaten
  );

  modport slave (
    input  tick, start, pacman_x, pacman_y, ghost_x, ghost_y, food_eaten, power_eaten,
    output state, lives, score, freeze, respawn, pacman_dead, game_over, frightened, ghost_eaten
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round / lives / score controller for the maze game.
// Sequences IDLE -> READY -> PLAY -> DYING -> (READY | OVER), counts lives,
// keeps a saturating score and drives freeze/respawn back to the sprite logic.
// Optional feature macro: GAME_ROUND_POWER_PELLET_EN (power pellets, frightened
// ghosts, ghost eating). Without it every hit is fatal and power_eaten is ignored.

// Per-ghost proximity test: both axes closer than HIT_DIST.
module game_round_hit #(
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int HIT_DIST = 8
) (
  input  logic [X_W-1:0] pacman_x,
  input  logic [Y_W-1:0] pacman_y,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  output logic           hit
);
  // One extra bit so the subtraction sign is never lost.
  localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

  logic [D_W-1:0] dx, dy, ax, ay;

  // Absolute differences on both axes, then the window compare.
  always_comb begin
    dx  = D_W'(pacman_x) - D_W'(ghost_x);
    dy  = D_W'(pacman_y) - D_W'(ghost_y);
    ax  = dx[D_W-1] ? (D_W'(0) - dx) : dx;
    ay  = dy[D_W-1] ? (D_W'(0) - dy) : dy;
    hit = (ax < D_W'(HIT_DIST)) && (ay < D_W'(HIT_DIST));
  end
endmodule

module game_round_ctrl #(
  parameter int NUM_GHOSTS   = 4,
  parameter int X_W          = 11,
  parameter int Y_W          = 10,
  parameter int SCORE_W      = 12,
  parameter int LIVES        = 3,
  parameter int HIT_DIST     = 8,
  parameter int FOOD_POINTS  = 1,
  parameter int READY_TICKS  = 32,
  parameter int DEATH_TICKS  = 64,
  parameter int FRIGHT_TICKS = 256,
  parameter int GHOST_POINTS = 20
) (
  input logic             clk,
  input logic             rst,
  game_round_ctrl_if.slave bus
);
  localparam int CNT_MAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUM_W   = SCORE_W + 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  respawn_q, respawn_d;
  logic                  dead_q, dead_d;
  logic                  freeze_q, freeze_d;
  logic                  over_q, over_d;
  logic                  fright_out_q, fright_out_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;

  logic [NUM_GHOSTS-1:0] hit;
  logic [NUM_GHOSTS-1:0] eat_vec;
  logic                  fright_on;
  logic                  sample;
  logic                  fatal;
  logic [3:0]            n_eat;
  logic [SUM_W-1:0]      sum;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
    game_round_hit #(.X_W(X_W), .Y_W(Y_W), .HIT_DIST(HIT_DIST)) u_hit (
      .pacman_x (bus.pacman_x),
      .pacman_y (bus.pacman_y),
      .ghost_x  (bus.ghost_x[g*X_W +: X_W]),
      .ghost_y  (bus.ghost_y[g*Y_W +: Y_W]),
      .hit      (hit[g])
    );
  end

  // Collisions only count on a movement tick while playing; frightened
  // status is the pre-decrement value so the tick that ends fright is safe.
  always_comb begin
    sample  = bus.tick && (state_q == S_PLAY);
    eat_vec = (sample && fright_on) ? hit : '0;
    fatal   = sample && !fright_on && (|hit);
    n_eat   = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) n_eat = n_eat + {3'b000, eat_vec[i]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic; tick counts are terminal on the tick that reaches N.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (bus.start) state_nxt = S_READY;
      S_READY: if (bus.tick && cnt_q == CNT_W'(READY_TICKS - 1)) state_nxt = S_PLAY;
      S_PLAY:  if (fatal) state_nxt = S_DYING;
      S_DYING: if (bus.tick && cnt_q == CNT_W'(DEATH_TICKS - 1))
                 state_nxt = (lives_q == 3'd0) ? S_OVER : S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything lands in registers below.
  always_comb begin
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    score_d   = score_q;
    respawn_d = (state_nxt == S_READY) && (state_q != S_READY);
    dead_d    = fatal;
    eaten_d   = eat_vec;
    freeze_d  = (state_nxt != S_PLAY);
    over_d    = (state_nxt == S_OVER);
    sum       = '0;

    if (state_nxt != state_q)
      cnt_d = '0;
    else if (bus.tick && (state_q == S_READY || state_q == S_DYING))
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          lives_d = 3'(LIVES);
          score_d = '0;
        end
      end
      S_PLAY: begin
        // Food and eaten ghosts accumulate together, clamped at all-ones.
        sum = SUM_W'(score_q)
            + (bus.food_eaten ? SUM_W'(FOOD_POINTS) : SUM_W'(0))
            + SUM_W'(n_eat) * SUM_W'(GHOST_POINTS);
        score_d = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
        if (fatal) lives_d = lives_q - 3'd1;
      end
      default: ;
    endcase
  end

`ifdef GAME_ROUND_POWER_PELLET_EN
  localparam int FR_W = $clog2(FRIGHT_TICKS + 1);
  logic [FR_W-1:0] fright_q, fright_d;

  assign fright_on = (fright_q != '0);

  // Fright timer: power pellet (re)loads, ticks drain, every READY entry clears.
  always_comb begin
    fright_d = fright_q;
    if (bus.tick && fright_q != '0) fright_d = fright_q - 1'b1;
    if (state_q == S_PLAY && bus.power_eaten) fright_d = FR_W'(FRIGHT_TICKS);
    if (respawn_d) fright_d = '0;
    fright_out_d = (fright_d != '0);
  end

  // Fright timer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fright_q <= '0;
    else      fright_q <= fright_d;
  end
`else
  logic unused_power;
  assign unused_power = bus.power_eaten;
  assign fright_on    = 1'b0;
  assign fright_out_d = 1'b0;
`endif

  // Registered outputs and round bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      lives_q      <= 3'(LIVES);
      score_q      <= '0;
      respawn_q    <= 1'b0;
      dead_q       <= 1'b0;
      freeze_q     <= 1'b1;
      over_q       <= 1'b0;
      fright_out_q <= 1'b0;
      eaten_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      respawn_q    <= respawn_d;
      dead_q       <= dead_d;
      freeze_q     <= freeze_d;
      over_q       <= over_d;
      fright_out_q <= fright_out_d;
      eaten_q      <= eaten_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.freeze      = freeze_q;
  assign bus.respawn     = respawn_q;
  assign bus.pacman_dead = dead_q;
  assign bus.game_over   = over_q;
  assign bus.frightened  = fright_out_q;
  assign bus.ghost_eaten = eaten_q;
endmodule
